// File: rtl/sequence_buffer_mem.sv
// rtl/sequence_buffer_mem.sv - DEPTH x DATA_SIZE register file, one sync write port, flat combinational read bus
module sequence_buffer_mem #(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SPACE_EXP = 3
) (
    input  logic                                      clk,
    input  logic                                      i_we,
    input  logic [ADDR_SPACE_EXP-1:0]                 i_waddr,
    input  logic [DATA_SIZE-1:0]                      i_wdata,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]  o_rd_bus
);
    localparam int DEPTH = 2**ADDR_SPACE_EXP;

    // Contents are deliberately left unreset; the owner masks stale slots by count.
    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign o_rd_bus[g*DATA_SIZE +: DATA_SIZE] = r_mem[g];
    end
endmodule

// File: rtl/sequence_buffer.sv
// rtl/sequence_buffer.sv - circular word buffer with push/pop/undo/clear and ordered snapshot
module sequence_buffer #(
    parameter int DATA_SIZE       = 8,
    parameter int ADDR_SPACE_EXP  = 3,
    parameter int ALMOST_FULL_LVL = 2**ADDR_SPACE_EXP-1
) (
    input  logic                                      clk_100MHz,
    input  logic                                      reset_n,
    input  logic                                      push,
    input  logic                                      pop,
    input  logic                                      undo,
    input  logic                                      clear,
    input  logic [DATA_SIZE-1:0]                      data_in,
    output logic [DATA_SIZE-1:0]                      head_out,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]  snapshot_out,
    output logic [ADDR_SPACE_EXP:0]                   count,
    output logic                                      empty,
    output logic                                      full,
    output logic                                      almost_full,
    output logic                                      overflow,
    output logic                                      underflow
);
    localparam int DEPTH = 2**ADDR_SPACE_EXP;
    localparam int CW    = ADDR_SPACE_EXP + 1;
    localparam int AW    = ADDR_SPACE_EXP;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LVL);

    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow, r_underflow;

    logic [AW-1:0] w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_overflow_nxt, w_underflow_nxt, w_we;
    logic          w_empty, w_full;
    logic [DATA_SIZE*DEPTH-1:0] w_mem_bus;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        w_we            = 1'b0;
        if (clear) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else if (push && pop) begin
            // When full, the write lands on the slot the pop just freed.
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            if (w_empty) begin
                w_count_nxt     = r_count + CW'(1);
                w_underflow_nxt = 1'b1;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            end
        end else if (push) begin
            if (w_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_we         = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                w_count_nxt  = r_count + CW'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                w_count_nxt  = r_count - CW'(1);
            end
        end else if (undo) begin
            if (w_empty) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr - AW'(1);
                w_count_nxt  = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    sequence_buffer_mem #(
        .DATA_SIZE      (DATA_SIZE),
        .ADDR_SPACE_EXP (ADDR_SPACE_EXP)
    ) u_mem (
        .clk      (clk_100MHz),
        .i_we     (w_we && reset_n),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (data_in),
        .o_rd_bus (w_mem_bus)
    );

    // Rotate so slot 0 is the head; slots past count read zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] w_idx;
        assign w_idx = r_rd_ptr + AW'(g);
        assign snapshot_out[g*DATA_SIZE +: DATA_SIZE] =
            (CW'(g) < r_count) ? w_mem_bus[w_idx*DATA_SIZE +: DATA_SIZE] : '0;
    end

    assign head_out    = snapshot_out[DATA_SIZE-1:0];
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= AF_CNT);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
endmodule

// File: tb/tb_sequence_buffer.sv
// tb/tb_sequence_buffer.sv - scoreboard bench for sequence_buffer against a queue model
module tb_sequence_buffer;
    localparam int D     = 8;
    localparam int A     = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 7;

    logic            clk_100MHz = 1'b0;
    logic            reset_n = 1'b0;
    logic            push = 1'b0, pop = 1'b0, undo = 1'b0, clear = 1'b0;
    logic [D-1:0]    data_in = '0;
    logic [D-1:0]    head_out;
    logic [D*DEPTH-1:0] snapshot_out;
    logic [A:0]      count;
    logic            empty, full, almost_full, overflow, underflow;

    sequence_buffer #(.DATA_SIZE(D), .ADDR_SPACE_EXP(A), .ALMOST_FULL_LVL(AFL)) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .undo         (undo),
        .clear        (clear),
        .data_in      (data_in),
        .head_out     (head_out),
        .snapshot_out (snapshot_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int             id;
        int             cnt;
        logic [D-1:0]   head;
        logic [D*DEPTH-1:0] snap;
        logic           emp, ful, af, ovf, unf;
    } exp_t;

    exp_t        exp_q[$];
    logic [D-1:0] model[$];
    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;

    task automatic chk(string name, int id, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a state; compare against the oldest expectation.
    always @(negedge clk_100MHz) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("count",       e.id, 64'(count),        64'(e.cnt));
            chk("head_out",    e.id, 64'(head_out),     64'(e.head));
            chk("snapshot",    e.id, 64'(snapshot_out), 64'(e.snap));
            chk("empty",       e.id, 64'(empty),        64'(e.emp));
            chk("full",        e.id, 64'(full),         64'(e.ful));
            chk("almost_full", e.id, 64'(almost_full),  64'(e.af));
            chk("overflow",    e.id, 64'(overflow),     64'(e.ovf));
            chk("underflow",   e.id, 64'(underflow),    64'(e.unf));
        end
    end

    task automatic step(bit p, bit po, bit u, bit c, logic [D-1:0] d, bit rst);
        exp_t e;
        bit ovf = 0, unf = 0;
        push = p; pop = po; undo = u; clear = c; data_in = d; reset_n = !rst;
        @(posedge clk_100MHz);
        #1;
        if (rst || c) begin
            model.delete();
        end else if (p && po) begin
            if (model.size() == 0) unf = 1;
            else void'(model.pop_front());
            model.push_back(d);
        end else if (p) begin
            if (model.size() == DEPTH) ovf = 1;
            else model.push_back(d);
        end else if (po) begin
            if (model.size() == 0) unf = 1;
            else void'(model.pop_front());
        end else if (u) begin
            if (model.size() == 0) unf = 1;
            else void'(model.pop_back());
        end
        e.id   = step_no;
        e.cnt  = model.size();
        e.snap = '0;
        foreach (model[i]) e.snap[i*D +: D] = model[i];
        e.head = (model.size() > 0) ? model[0] : '0;
        e.emp  = (model.size() == 0);
        e.ful  = (model.size() == DEPTH);
        e.af   = (model.size() >= AFL);
        e.ovf  = ovf;
        e.unf  = unf;
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic do_push(logic [D-1:0] d); step(1, 0, 0, 0, d, 0); endtask
    task automatic do_pop();                 step(0, 1, 0, 0, 8'h00, 0); endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_no);
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 1);
        do_push(8'h53); do_push(8'h49); do_push(8'h4D);
        step(0, 0, 0, 0, 8'h00, 1);
        for (int i = 1; i <= 9; i++) do_push(8'(i));
        do_push(8'h0A);
        for (int i = 0; i < 3; i++) do_pop();
        do_push(8'hA1); do_push(8'hA2); do_push(8'hA3);
        step(1, 1, 0, 0, 8'hB0, 0);
        step(0, 0, 0, 1, 8'h00, 0);
        do_push(8'h41); do_push(8'h42);
        step(0, 0, 1, 0, 8'h00, 0);
        do_push(8'h43);
        step(0, 0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 0, 8'h00, 0);
        step(0, 0, 1, 0, 8'h00, 0);
        step(1, 1, 0, 0, 8'h55, 0);
        step(1, 0, 0, 1, 8'h66, 0);
        // Undo across pointer wrap: write pointer sits at 0 after eight pushes.
        step(0, 0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 8; i++) do_push(8'h70 + 8'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00, 0);
        do_push(8'h7F);
        // Reset mid-burst with push held high.
        for (int i = 0; i < 4; i++) do_push(8'h90 + 8'(i));
        step(1, 0, 0, 0, 8'h94, 1);
        for (int i = 0; i < 3; i++) do_push(8'hC0 + 8'(i));
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 20, (r >= 2 && r < 5),
                 8'($urandom), (r < 2));
        end
        step(0, 0, 0, 0, 8'h00, 0);
        repeat (3) @(posedge clk_100MHz);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
